// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and state encoding for the IF stage.
package if_fetch_stage_pkg;
  localparam int IF_INSTR_WIDTH = 32;
  localparam logic [IF_INSTR_WIDTH-1:0] IF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_HOLD  = 2'd2,
    IF_DROP  = 2'd3
  } if_state_e;
endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush invalidates, stall holds, otherwise loads an
// instruction or a bubble (bubble keeps the old PC/instr fields).
module if_fetch_stage_if_id_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         stall,
  input  logic         load_valid,
  input  logic [W-1:0] load_pc,
  input  logic [W-1:0] load_instr,
  output logic         id_valid,
  output logic [W-1:0] id_pc,
  output logic [W-1:0] id_instr
);
  logic         valid_q, valid_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d = load_valid;
      if (load_valid) begin
        pc_d    = load_pc;
        instr_d = load_instr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign id_valid = valid_q;
  assign id_pc    = pc_q;
  assign id_instr = instr_q;
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, imem req/ack handshake, one-entry
// stall buffer and the IF/ID register.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int INSTR_WIDTH = IF_INSTR_WIDTH,
  parameter logic [INSTR_WIDTH-1:0] RESET_PC = IF_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] W_next_pc,
  input  logic                   W_stall,
  input  logic                   W_flush,
  input  logic [INSTR_WIDTH-1:0] W_flush_pc,
  output logic                   W_imem_req,
  output logic [INSTR_WIDTH-1:0] W_imem_addr,
  input  logic                   W_imem_ack,
  input  logic [INSTR_WIDTH-1:0] W_imem_rdata,
  output logic [INSTR_WIDTH-1:0] W_pc,
  output logic [INSTR_WIDTH-1:0] W_ID_PC,
  output logic [INSTR_WIDTH-1:0] W_ID_instr,
  output logic                   W_ID_valid
);
  if_state_e              state_q, state_d;
  logic [INSTR_WIDTH-1:0] pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] drop_addr_q, drop_addr_d;
  logic [INSTR_WIDTH-1:0] buf_q, buf_d;
  logic                   id_load_valid;
  logic [INSTR_WIDTH-1:0] id_load_instr;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_addr_d   = drop_addr_q;
    buf_d         = buf_q;
    id_load_valid = 1'b0;
    id_load_instr = W_imem_rdata;
    W_imem_req    = 1'b0;
    W_imem_addr   = pc_q;
    case (state_q)
      IF_IDLE: begin
        state_d = IF_FETCH;
        if (W_flush) pc_d = W_flush_pc;
      end
      IF_FETCH: begin
        W_imem_req = 1'b1;
        if (W_flush) begin
          pc_d = W_flush_pc;
          // The abandoned request must still complete before refetching.
          if (!W_imem_ack) begin
            drop_addr_d = pc_q;
            state_d     = IF_DROP;
          end
        end else if (W_imem_ack) begin
          if (W_stall) begin
            buf_d   = W_imem_rdata;
            state_d = IF_HOLD;
          end else begin
            id_load_valid = 1'b1;
            pc_d          = W_next_pc;
          end
        end
      end
      IF_HOLD: begin
        if (W_flush) begin
          pc_d    = W_flush_pc;
          buf_d   = '0;
          state_d = IF_FETCH;
        end else if (!W_stall) begin
          id_load_valid = 1'b1;
          id_load_instr = buf_q;
          pc_d          = W_next_pc;
          state_d       = IF_FETCH;
        end
      end
      IF_DROP: begin
        W_imem_req  = 1'b1;
        W_imem_addr = drop_addr_q;
        if (W_flush) pc_d = W_flush_pc;
        if (W_imem_ack) state_d = IF_FETCH;
      end
      default: state_d = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IF_IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      buf_q       <= buf_d;
    end
  end

  assign W_pc = pc_q;

  if_fetch_stage_if_id_reg #(.W(INSTR_WIDTH)) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .flush      (W_flush),
    .stall      (W_stall),
    .load_valid (id_load_valid),
    .load_pc    (pc_q),
    .load_instr (id_load_instr),
    .id_valid   (W_ID_valid),
    .id_pc      (W_ID_PC),
    .id_instr   (W_ID_instr)
  );
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed vector table for the fetch corner cases, then a randomized run
// checked against an in-order instruction stream model.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] W_next_pc;
  logic        W_stall;
  logic        W_flush;
  logic [31:0] W_flush_pc;
  logic        W_imem_req;
  logic [31:0] W_imem_addr;
  logic        W_imem_ack;
  logic [31:0] W_imem_rdata;
  logic [31:0] W_pc;
  logic [31:0] W_ID_PC;
  logic [31:0] W_ID_instr;
  logic        W_ID_valid;

  logic        jump_en;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  // Environment: memory returns the word for whatever address is requested;
  // NextPC is sequential unless a branch target is injected.
  assign W_imem_rdata = instr_of(W_imem_addr);
  assign W_next_pc    = jump_en ? 32'h0000_0200 : W_pc + 32'd4;

  if_fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .W_next_pc    (W_next_pc),
    .W_stall      (W_stall),
    .W_flush      (W_flush),
    .W_flush_pc   (W_flush_pc),
    .W_imem_req   (W_imem_req),
    .W_imem_addr  (W_imem_addr),
    .W_imem_ack   (W_imem_ack),
    .W_imem_rdata (W_imem_rdata),
    .W_pc         (W_pc),
    .W_ID_PC      (W_ID_PC),
    .W_ID_instr   (W_ID_instr),
    .W_ID_valid   (W_ID_valid)
  );

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] fpc;
    logic        ack;
    logic        jmp;
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic        v;
    logic [31:0] idpc;
  } vec_t;

  vec_t tbl[40];

  function automatic vec_t mk(input logic r, input logic s, input logic f,
                              input logic [31:0] fp, input logic a, input logic j,
                              input logic c, input logic rq, input logic [31:0] ad,
                              input logic [31:0] p, input logic vv, input logic [31:0] ip);
    vec_t t;
    t = '{rst: r, stall: s, flush: f, fpc: fp, ack: a, jmp: j, chk: c,
          req: rq, addr: ad, pc: p, v: vv, idpc: ip};
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    // rst stall flush fpc ack jmp | chk req addr pc v idpc
    // Zero-wait memory, back-to-back commits
    tbl[0]  = mk(1,0,0,32'h0,1'b0,0, 0,0,32'h0,32'h0,0,32'h0);
    tbl[1]  = mk(0,0,0,32'h0,1'b0,0, 1,0,32'h0,32'h0,0,32'h0);
    tbl[2]  = mk(0,0,0,32'h0,1'b1,0, 1,1,32'h0,32'h0,0,32'h0);
    tbl[3]  = mk(0,0,0,32'h0,1'b1,0, 1,1,32'h4,32'h4,1,32'h0);
    tbl[4]  = mk(0,0,0,32'h0,1'b1,0, 1,1,32'h8,32'h8,1,32'h4);
    tbl[5]  = mk(0,0,0,32'h0,1'b1,0, 1,1,32'hC,32'hC,1,32'h8);
    // Reset with an ack pending, then 2-wait-state memory
    tbl[6]  = mk(1,0,0,32'h0,1'b1,0, 1,1,32'h10,32'h10,1,32'hC);
    tbl[7]  = mk(0,0,0,32'h0,1'b0,0, 1,0,32'h0,32'h0,0,32'h0);
    tbl[8]  = mk(0,0,0,32'h0,1'b1,0, 1,1,32'h0,32'h0,0,32'h0);
    tbl[9]  = mk(0,0,0,32'h0,1'b0,0, 1,1,32'h4,32'h4,1,32'h0);
    tbl[10] = mk(0,0,0,32'h0,1'b0,0, 1,1,32'h4,32'h4,0,32'h0);
    tbl[11] = mk(0,0,0,32'h0,1'b1,0, 1,1,32'h4,32'h4,0,32'h0);
    tbl[12] = mk(0,0,0,32'h0,1'b0,0, 1,1,32'h8,32'h8,1,32'h4);
    tbl[13] = mk(0,0,0,32'h0,1'b0,0, 1,1,32'h8,32'h8,0,32'h4);
    tbl[14] = mk(0,0,0,32'h0,1'b1,0, 1,1,32'h8,32'h8,0,32'h4);
    tbl[15] = mk(0,0,0,32'h0,1'b1,0, 1,1,32'hC,32'hC,1,32'h8);
    // Stall while 0x8 is acked: HOLD for three cycles
    tbl[16] = mk(1,0,0,32'h0,1'b0,0, 1,1,32'h10,32'h10,1,32'hC);
    tbl[17] = mk(0,0,0,32'h0,1'b0,0, 1,0,32'h0,32'h0,0,32'h0);
    tbl[18] = mk(0,0,0,32'h0,1'b1,0, 1,1,32'h0,32'h0,0,32'h0);
    tbl[19] = mk(0,0,0,32'h0,1'b1,0, 1,1,32'h4,32'h4,1,32'h0);
    tbl[20] = mk(0,1,0,32'h0,1'b1,0, 1,1,32'h8,32'h8,1,32'h4);
    tbl[21] = mk(0,1,0,32'h0,1'b0,0, 1,0,32'h8,32'h8,1,32'h4);
    tbl[22] = mk(0,1,0,32'h0,1'b0,0, 1,0,32'h8,32'h8,1,32'h4);
    tbl[23] = mk(0,0,0,32'h0,1'b0,0, 1,0,32'h8,32'h8,1,32'h4);
    tbl[24] = mk(0,0,0,32'h0,1'b1,0, 1,1,32'hC,32'hC,1,32'h8);
    // Flush to 0x80 while 0x10 is outstanding -> DROP
    tbl[25] = mk(0,0,1,32'h80,1'b0,0, 1,1,32'h10,32'h10,1,32'hC);
    tbl[26] = mk(0,0,0,32'h0,1'b0,0, 1,1,32'h10,32'h80,0,32'hC);
    tbl[27] = mk(0,0,0,32'h0,1'b1,0, 1,1,32'h10,32'h80,0,32'hC);
    tbl[28] = mk(0,0,0,32'h0,1'b1,0, 1,1,32'h80,32'h80,0,32'hC);
    // Flush + stall + ack in one cycle
    tbl[29] = mk(0,1,1,32'h40,1'b1,0, 1,1,32'h84,32'h84,1,32'h80);
    tbl[30] = mk(0,0,0,32'h0,1'b1,0, 1,1,32'h40,32'h40,0,32'h80);
    // Branch at 0x100, delay slot 0x104 commits with NextPC = 0x200
    tbl[31] = mk(0,0,1,32'h100,1'b1,0, 1,1,32'h44,32'h44,1,32'h40);
    tbl[32] = mk(0,0,0,32'h0,1'b1,0, 1,1,32'h100,32'h100,0,32'h40);
    tbl[33] = mk(0,1,0,32'h0,1'b1,0, 1,1,32'h104,32'h104,1,32'h100);
    tbl[34] = mk(0,0,0,32'h0,1'b0,1, 1,0,32'h104,32'h104,1,32'h100);
    tbl[35] = mk(0,0,0,32'h0,1'b1,0, 1,1,32'h200,32'h200,1,32'h104);
    // Reset mid-ack, then PC wrap at 0xFFFF_FFFC
    tbl[36] = mk(1,0,0,32'h0,1'b1,0, 1,1,32'h204,32'h204,1,32'h200);
    tbl[37] = mk(0,0,1,32'hFFFF_FFFC,1'b0,0, 1,0,32'h0,32'h0,0,32'h0);
    tbl[38] = mk(0,0,0,32'h0,1'b1,0, 1,1,32'hFFFF_FFFC,32'hFFFF_FFFC,0,32'h0);
    tbl[39] = mk(0,0,0,32'h0,1'b0,0, 1,1,32'h0,32'h0,1,32'hFFFF_FFFC);
  end

  initial begin
    int          pending;
    int          wait_n;
    int          consumed;
    logic [31:0] exp_pc;

    rst = 1'b1; W_stall = 1'b0; W_flush = 1'b0; W_flush_pc = '0;
    W_imem_ack = 1'b0; jump_en = 1'b0;
    #1;

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rst        = tbl[i].rst;
      W_stall    = tbl[i].stall;
      W_flush    = tbl[i].flush;
      W_flush_pc = tbl[i].fpc;
      W_imem_ack = tbl[i].ack;
      jump_en    = tbl[i].jmp;
      #1;
      if (tbl[i].chk) begin
        check("req", i, {31'd0, W_imem_req}, {31'd0, tbl[i].req});
        if (tbl[i].req) check("addr", i, W_imem_addr, tbl[i].addr);
        check("pc", i, W_pc, tbl[i].pc);
        check("id_valid", i, {31'd0, W_ID_valid}, {31'd0, tbl[i].v});
        check("id_pc", i, W_ID_PC, tbl[i].idpc);
        if (tbl[i].v) check("id_instr", i, W_ID_instr, instr_of(tbl[i].idpc));
        if (i > 0 && tbl[i-1].rst) check("id_instr_rst", i, W_ID_instr, 32'h0);
      end
      $display("[TB] vec %0d req=%0b addr=%h pc=%h idv=%0b idpc=%h", i,
               W_imem_req, W_imem_addr, W_pc, W_ID_valid, W_ID_PC);
    end

    // Randomized run: every instruction ID accepts must be the next in the
    // architectural stream (sequential, restarted at each flush target).
    @(negedge clk);
    rst = 1'b1; W_stall = 1'b0; W_flush = 1'b0; W_imem_ack = 1'b0; jump_en = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    exp_pc   = 32'h0;
    pending  = 0;
    wait_n   = $urandom_range(0, 2);
    consumed = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      W_stall    = ($urandom_range(0, 3) == 0);
      W_flush    = ($urandom_range(0, 39) == 0);
      W_flush_pc = $urandom & 32'hFFFF_FFFC;
      W_imem_ack = W_imem_req && (pending >= wait_n);
      #1;
      if (W_flush) begin
        exp_pc = W_flush_pc;
      end else if (W_ID_valid && !W_stall) begin
        check("rnd_id_pc", cyc, W_ID_PC, exp_pc);
        check("rnd_id_instr", cyc, W_ID_instr, instr_of(exp_pc));
        if (consumed % 200 == 0)
          $display("[TB] rnd cyc %0d id_pc=%h instr=%h", cyc, W_ID_PC, W_ID_instr);
        exp_pc   = exp_pc + 32'd4;
        consumed = consumed + 1;
      end
      if (W_imem_req) begin
        if (W_imem_ack) begin
          pending = 0;
          wait_n  = $urandom_range(0, 2);
        end else begin
          pending = pending + 1;
        end
      end
    end
    check("rnd_throughput", 0, (consumed >= 400) ? 32'd1 : 32'd0, 32'd1);
    $display("[TB] random run consumed %0d instructions", consumed);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
